fifo_rd_fwft: RTL

- Read-side output stage of the async FIFO, in the r_clk domain, directly downstream of the read-pointer/empty block and the dual-port memory.
- Converts the FIFO's pop interface (empty, rd_rq, registered memory rdata) into a first-word-fall-through valid/ready stream.
- A 2-entry output buffer keeps full throughput under backpressure with no data loss.

---
 rtl/fifo_rd_fwft.sv | 72 +++++++
 1 files changed

// File: rtl/fifo_rd_fwft.sv
// fifo_rd_fwft: read-side output stage of the async FIFO (r_clk domain).
// It turns the pop interface (empty / rd_rq / registered rdata) into a
// first-word-fall-through valid/ready stream. A 2-entry head/tail buffer
// lets it keep one word per cycle even when the consumer stalls.
module fifo_rd_fwft #(
   parameter int WIDTH = 8
) (
   input  logic             r_clk,
   input  logic             rst_n,
   input  logic             empty,
   output logic             rd_rq,
   input  logic [WIDTH-1:0] rdata,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_count
);

   logic [WIDTH-1:0] r_head;
   logic [WIDTH-1:0] r_tail;
   logic [1:0]       r_occ;
   logic             r_inflight;
   logic             r_valid;

   logic             w_pop;
   logic             w_rq;
   logic [1:0]       w_credit;
   logic [1:0]       w_occ_after_pop;
   logic [1:0]       w_occ_next;

   // Credit accounting: a pop is requested only while buffered words plus
   // the word in flight, less the one leaving now, leave room in the buffer.
   // That caps credit at 2, so occ can never pass 2.
   always_comb begin
      w_pop           = r_valid & out_ready;
      w_credit        = r_occ + {1'b0, r_inflight};
      w_rq            = rst_n & ~empty & ((w_credit - {1'b0, w_pop}) < 2'd2);
      w_occ_after_pop = r_occ - {1'b0, w_pop};
      w_occ_next      = w_occ_after_pop + {1'b0, r_inflight};
   end

   assign rd_rq     = w_rq;
   assign out_valid = r_valid;
   assign out_data  = r_head;
   assign out_count = r_occ;

   // Buffer update: pop shifts tail into head; a returning word lands in the
   // head when the head is free after this pop, else in the tail. rdata is
   // only sampled while a read is in flight, so garbage never reaches out_data.
   always_ff @(posedge r_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_occ      <= 2'd0;
         r_inflight <= 1'b0;
         r_valid    <= 1'b0;
      end else begin
         r_occ      <= w_occ_next;
         r_valid    <= (w_occ_next != 2'd0);
         r_inflight <= w_rq;
         if (w_pop && (r_occ == 2'd2))
            r_head <= r_tail;
         if (r_inflight) begin
            if (w_occ_after_pop == 2'd0)
               r_head <= rdata;
            else
               r_tail <= rdata;
         end
      end
   end

endmodule
